// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: shared prescaler and period counter, per-channel
// double-buffered duty, edge- or center-aligned, all reconfiguration at period boundaries.
module pwm_multi #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 4,
    parameter int PRE_W    = 8,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [WIDTH-1:0]    cfg_period,
    input  logic [PRE_W-1:0]    cfg_prescale,
    input  logic                cfg_center,
    input  logic                wr_en,
    input  logic [CH_W-1:0]     wr_ch,
    input  logic [WIDTH-1:0]    wr_duty,
    input  logic [CHANNELS-1:0] ch_en,
    input  logic [CHANNELS-1:0] ch_inv,
    output logic [CHANNELS-1:0] pwm,
    output logic                period_tick
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PRE_W-1:0] PRE_ZERO = {PRE_W{1'b0}};
    localparam logic [PRE_W-1:0] PRE_ONE  = {{(PRE_W-1){1'b0}}, 1'b1};

    logic [PRE_W-1:0]    pre_cnt_r;
    logic [PRE_W-1:0]    pre_act_r;
    logic [WIDTH-1:0]    cnt_r;
    logic [WIDTH-1:0]    top_act_r;
    logic                dir_up_r;
    logic                center_act_r;
    logic [WIDTH-1:0]    shadow_r   [CHANNELS];
    logic [WIDTH-1:0]    duty_act_r [CHANNELS];
    logic [CHANNELS-1:0] pwm_r;
    logic                period_tick_r;

    logic                tick_s;
    logic                boundary_s;
    logic [PRE_W-1:0]    pre_cnt_nxt_s;
    logic [WIDTH-1:0]    cnt_nxt_s;
    logic                dir_up_nxt_s;
    logic [CHANNELS-1:0] raw_s;
    logic [CHANNELS-1:0] pwm_nxt_s;

    // Prescaler and period counter next-state, including boundary detection
    always_comb begin
        tick_s        = (pre_cnt_r == pre_act_r);
        pre_cnt_nxt_s = pre_cnt_r;
        cnt_nxt_s     = cnt_r;
        dir_up_nxt_s  = dir_up_r;
        boundary_s    = 1'b0;
        if (tick_s) begin
            pre_cnt_nxt_s = PRE_ZERO;
            if (top_act_r == CNT_ZERO) begin
                cnt_nxt_s    = CNT_ZERO;
                dir_up_nxt_s = 1'b1;
                boundary_s   = 1'b1;
            end else if (!center_act_r) begin
                // Edge mode wraps top->0; >= keeps the counter bounded defensively
                if (cnt_r >= top_act_r) begin
                    cnt_nxt_s    = CNT_ZERO;
                    dir_up_nxt_s = 1'b1;
                    boundary_s   = 1'b1;
                end else begin
                    cnt_nxt_s    = cnt_r + CNT_ONE;
                end
            end else if (dir_up_r) begin
                if (cnt_r >= top_act_r) begin
                    cnt_nxt_s    = top_act_r - CNT_ONE;
                    dir_up_nxt_s = 1'b0;
                end else begin
                    cnt_nxt_s    = cnt_r + CNT_ONE;
                    dir_up_nxt_s = ((cnt_r + CNT_ONE) < top_act_r);
                end
            end else begin
                if (cnt_r <= CNT_ONE) begin
                    cnt_nxt_s    = CNT_ZERO;
                    dir_up_nxt_s = 1'b1;
                    boundary_s   = 1'b1;
                end else begin
                    cnt_nxt_s    = cnt_r - CNT_ONE;
                end
            end
        end else begin
            pre_cnt_nxt_s = pre_cnt_r + PRE_ONE;
        end
    end

    // Per-channel compare with live enable and polarity
    always_comb begin
        raw_s     = {CHANNELS{1'b0}};
        pwm_nxt_s = {CHANNELS{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            raw_s[i] = (duty_act_r[i] > cnt_r);
            if (ch_en[i]) begin
                pwm_nxt_s[i] = raw_s[i] ^ ch_inv[i];
            end else begin
                pwm_nxt_s[i] = ch_inv[i];
            end
        end
    end

    // Counter state and boundary-latched configuration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_r    <= PRE_ZERO;
            cnt_r        <= CNT_ZERO;
            dir_up_r     <= 1'b1;
            top_act_r    <= CNT_ZERO;
            pre_act_r    <= PRE_ZERO;
            center_act_r <= 1'b0;
        end else begin
            pre_cnt_r <= pre_cnt_nxt_s;
            cnt_r     <= cnt_nxt_s;
            dir_up_r  <= dir_up_nxt_s;
            if (boundary_s) begin
                top_act_r    <= cfg_period;
                pre_act_r    <= cfg_prescale;
                center_act_r <= cfg_center;
            end
        end
    end

    // Shadow duty writes; out-of-range channels match no slot and are dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                shadow_r[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_en && (wr_ch == CH_W'(i))) begin
                    shadow_r[i] <= wr_duty;
                end
            end
        end
    end

    // Active duty transfer: same-cycle writes miss this load by design
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                duty_act_r[i] <= CNT_ZERO;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (boundary_s) begin
                    duty_act_r[i] <= shadow_r[i];
                end
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_r         <= {CHANNELS{1'b0}};
            period_tick_r <= 1'b0;
        end else begin
            pwm_r         <= pwm_nxt_s;
            period_tick_r <= boundary_s;
        end
    end

    assign pwm         = pwm_r;
    assign period_tick = period_tick_r;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi: expected {period_tick, pwm} per clock is queued
// from the period formulas and popped against the DUT on every falling edge.
module tb_pwm_multi;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 2;
    localparam int PRE_W    = 8;
    localparam int CH_W     = 2;

    logic                clk;
    logic                rst_n;
    logic [WIDTH-1:0]    cfg_period;
    logic [PRE_W-1:0]    cfg_prescale;
    logic                cfg_center;
    logic                wr_en;
    logic [CH_W-1:0]     wr_ch;
    logic [WIDTH-1:0]    wr_duty;
    logic [CHANNELS-1:0] ch_en;
    logic [CHANNELS-1:0] ch_inv;
    logic [CHANNELS-1:0] pwm;
    logic                period_tick;

    int         checks = 0;
    int         errors = 0;
    logic [2:0] exp_q[$];

    pwm_multi #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .PRE_W(PRE_W), .CH_W(CH_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_period(cfg_period), .cfg_prescale(cfg_prescale),
        .cfg_center(cfg_center), .wr_en(wr_en), .wr_ch(wr_ch), .wr_duty(wr_duty),
        .ch_en(ch_en), .ch_inv(ch_inv), .pwm(pwm), .period_tick(period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bits(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    // One full period of expectations, starting the clock after period_tick
    task automatic push_period(input int p, input int s, input bit center, input int d0, input int d1);
        int n;
        n = center ? 2 * p * (s + 1) : (p + 1) * (s + 1);
        for (int j = 0; j < n; j++) begin
            int         c;
            int         cv;
            logic [1:0] raw;
            logic [1:0] outv;
            c    = j / (s + 1);
            cv   = (center && (c > p)) ? (2 * p - c) : c;
            raw  = {(d1 > cv), (d0 > cv)};
            outv = ((raw ^ ch_inv) & ch_en) | (ch_inv & ~ch_en);
            exp_q.push_back({(j == n - 1), outv});
        end
    endtask

    task automatic step_check(input string tag);
        logic [2:0] e;
        @(negedge clk);
        e = exp_q.pop_front();
        check_bits(tag, {5'd0, period_tick, pwm}, {5'd0, e});
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            step_check(tag);
        end
    endtask

    task automatic sync_boundary();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (period_tick === 1'b1) found = 1'b1;
        end
        checks++;
        assert (found) else begin
            errors++;
            $error("FAIL sync: observed no period_tick within 200 clocks, expected one");
        end
    endtask

    task automatic write_duty(input logic [CH_W-1:0] ch, input logic [WIDTH-1:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_ch   = ch;
        wr_duty = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        cfg_period   = 4'd9;
        cfg_prescale = 8'd0;
        cfg_center   = 1'b0;
        wr_en        = 1'b0;
        wr_ch        = 2'd0;
        wr_duty      = 4'd0;
        ch_en        = 2'b11;
        ch_inv       = 2'b11;
        #12;
        check_bits("reset_state", {5'd0, period_tick, pwm}, 8'd0);
        ch_inv = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // Edge basic
        write_duty(2'd0, 4'd3);
        write_duty(2'd1, 4'd6);
        sync_boundary();
        sync_boundary();
        push_period(9, 0, 1'b0, 3, 6);
        push_period(9, 0, 1'b0, 3, 6);
        drain("edge_basic");

        // Extremes: duty 0 and duty above top
        write_duty(2'd0, 4'd0);
        write_duty(2'd1, 4'd10);
        sync_boundary();
        sync_boundary();
        push_period(9, 0, 1'b0, 0, 10);
        drain("extreme_duty");

        // Extremes: inverted enabled channel and disabled inverted idle
        write_duty(2'd0, 4'd3);
        ch_en  = 2'b01;
        ch_inv = 2'b11;
        sync_boundary();
        sync_boundary();
        push_period(9, 0, 1'b0, 3, 10);
        drain("inv_idle");
        ch_en  = 2'b11;
        ch_inv = 2'b00;

        // Center mode
        cfg_center = 1'b1;
        cfg_period = 4'd4;
        write_duty(2'd0, 4'd2);
        write_duty(2'd1, 4'd1);
        sync_boundary();
        sync_boundary();
        push_period(4, 0, 1'b1, 2, 1);
        push_period(4, 0, 1'b1, 2, 1);
        drain("center");

        // Prescale
        cfg_center   = 1'b0;
        cfg_period   = 4'd9;
        cfg_prescale = 8'd1;
        write_duty(2'd0, 4'd5);
        write_duty(2'd1, 4'd9);
        sync_boundary();
        sync_boundary();
        push_period(9, 1, 1'b0, 5, 9);
        push_period(9, 1, 1'b0, 5, 9);
        drain("prescale");

        // Shadow: mid-period write applies next period
        cfg_prescale = 8'd0;
        write_duty(2'd0, 4'd3);
        write_duty(2'd1, 4'd0);
        sync_boundary();
        sync_boundary();
        push_period(9, 0, 1'b0, 3, 0);
        push_period(9, 0, 1'b0, 7, 0);
        for (int i = 0; i < 20; i++) begin
            step_check("shadow_mid");
            if (i == 3) begin
                wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 4'd7;
            end else begin
                wr_en = 1'b0;
            end
        end

        // Shadow: write in the boundary cycle is one period late
        write_duty(2'd0, 4'd3);
        sync_boundary();
        sync_boundary();
        push_period(9, 0, 1'b0, 3, 0);
        push_period(9, 0, 1'b0, 3, 0);
        push_period(9, 0, 1'b0, 7, 0);
        for (int i = 0; i < 30; i++) begin
            step_check("shadow_boundary");
            if (i == 8) begin
                wr_en = 1'b1; wr_ch = 2'd0; wr_duty = 4'd7;
            end else begin
                wr_en = 1'b0;
            end
        end

        // Out-of-range channel writes are ignored
        write_duty(2'd3, 4'd5);
        write_duty(2'd2, 4'd5);
        sync_boundary();
        sync_boundary();
        push_period(9, 0, 1'b0, 7, 0);
        drain("bad_channel");

        // Reset mid-period while pwm is high
        write_duty(2'd0, 4'd5);
        sync_boundary();
        sync_boundary();
        @(negedge clk);
        check_bits("pre_reset_high", {7'd0, pwm[0]}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_bits("async_reset", {5'd0, period_tick, pwm}, 8'd0);
        @(negedge clk);
        check_bits("reset_hold", {5'd0, period_tick, pwm}, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_bits("post_reset_tick", {5'd0, period_tick, pwm}, 8'b0000_0100);
        push_period(9, 0, 1'b0, 0, 0);
        drain("shadow_lost");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator for the drive and brush motors. It is the parametrised successor of the single-channel comparator PWM. All channels share one clock-enable prescaler and one period counter. Each channel has its own double-buffered duty register, enable, and polarity. Edge-aligned and center-aligned modes are supported, and every configuration change takes effect only at a period boundary, so outputs never glitch.

## Interface

**Parameters**
- WIDTH, 10: counter, period and duty width.
- CHANNELS, 4: number of PWM outputs (≥1).
- PRE_W, 8: prescaler width.
- CH_W, max(1, clog2(CHANNELS)): channel-select width (derived).

**Ports**
- clk, input, 1: single system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- cfg_period, input, WIDTH: TOP value of the period counter.
- cfg_prescale, input, PRE_W: counter advances once every cfg_prescale+1 clocks.
- cfg_center, input, 1: 0 = edge-aligned, 1 = center-aligned.
- wr_en, input, 1: duty write strobe, one write per clock.
- wr_ch, input, CH_W: target channel; values ≥ CHANNELS are ignored.
- wr_duty, input, WIDTH: duty value written to the shadow register.
- ch_en, input, CHANNELS: per-channel enable, applied live.
- ch_inv, input, CHANNELS: per-channel output inversion, applied live.
- pwm, output, CHANNELS: registered PWM outputs.
- period_tick, output, 1: one-clock pulse per period boundary.

## Operation

- **Prescaler**
  - pre_cnt counts 0..pre_act.
  - tick = (pre_cnt == pre_act), and pre_cnt returns to 0 on tick.
  - pre_act = 0 gives a tick every clock.
- **Edge mode**
  - cnt counts 0..top_act on ticks, then wraps to 0.
  - Period = (top_act+1)·(pre_act+1) clocks.
- **Center mode**
  - cnt counts up to top_act, then down to 0, then up again. Direction flips on the tick where cnt reaches top_act or 0.
  - Period = 2·top_act·(pre_act+1) clocks.
  - top_act = 0 holds cnt at 0, and every tick is a boundary.
- **Period boundary**
  - Edge mode: the tick at which cnt goes top_act→0.
  - Center mode: the tick at which cnt reaches 0 while counting down.
  - If top_act = 0, every tick is a boundary in either mode.
- **Loads at the boundary edge**
  - top_act ← cfg_period, pre_act ← cfg_prescale, center_act ← cfg_center.
  - duty_act[i] ← shadow[i] for every channel.
  - On a mode change, direction restarts as up.
- **Duty writes**
  - wr_en with wr_ch < CHANNELS stores wr_duty into shadow[wr_ch] on the next edge.
  - A write in the same cycle as a boundary does not reach duty_act; the pre-write shadow is loaded and the new value applies from the following period.
- **Compare and output**
  - raw[i] = (duty_act[i] > cnt).
  - duty 0 gives a constant inactive output. Duty > top_act gives a constant active output.
  - pwm[i] ← ch_en[i] ? raw[i]^ch_inv[i] : ch_inv[i]. A disabled channel drives its idle level.
- **Width rule:** the compare is unsigned WIDTH-bit. The counter never exceeds top_act, and no overflow is possible.

## Timing

- **Reset (async assert, sync-safe deassert)**
  - pre_cnt, cnt, top_act, pre_act, center_act, all shadow and duty_act = 0; direction = up.
  - pwm = 0 on all channels, independent of ch_inv. period_tick = 0.
- **After reset:** top_act = pre_act = 0, so the first clock is a boundary. The live cfg_* values load on the first rising edge after rst_n deasserts.
- **Latency**
  - pwm[i] reflects cnt and duty_act one clock after those registers update. Changes on ch_en or ch_inv appear on pwm one clock later.
  - period_tick is registered: it is high in the first clock where cnt = 0 and the new duty_act values are in effect.
- **Mid-period changes:** changes to cfg_period, cfg_prescale or cfg_center have no effect until the next boundary.
- **Reset mid-period:** outputs go to 0 immediately and asynchronously, and all shadow values are lost.

## Test plan

- **Edge basic.** WIDTH=4, CHANNELS=2, period=9, prescale=0, edge mode, duty ch0=3, ch_en=11. Required: ch0 high for 3 of every 10 clocks, and period_tick every 10 clocks.
- **Extremes.** Duty 0 gives pwm constantly 0. Duty 10 with period=9 gives pwm constantly 1. ch_inv=1 with ch_en=0 gives pwm constantly 1.
- **Center mode.** period=4, duty=2. Required: cnt sequence 0,1,2,3,4,3,2,1 repeating, pwm high for 3 of every 8 clocks, period_tick every 8 clocks.
- **Prescale.** prescale=1, period=9, duty=5. Required: 10 high clocks out of every 20, period_tick every 20 clocks.
- **Shadow buffering.** Write duty 7 in the middle of a period with duty 3. Required: the current period stays at 3. Repeat the write in the exact boundary cycle; required: 7 takes effect one period later. A write with wr_ch=3 when CHANNELS=2 changes nothing.
- **Reset mid-period.** Pull rst_n low while pwm is high. Required: pwm=0 and period_tick=0 asynchronously. After release, the first clock is a boundary and period_tick pulses on the next clock.
